// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: FSM encodings,
// bit-timing shifts and counter widths.
package uart_pkg;

    localparam int unsigned PRESCALE_W     = 16;
    localparam int unsigned PRESCALE_SHIFT = 3;
    localparam int unsigned HALF_SHIFT     = 2;
    localparam int unsigned CNT_W          = PRESCALE_W + PRESCALE_SHIFT;
    localparam int unsigned BCNT_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Reload value for a down-counter covering (p << sh) cycles.
    function automatic logic [CNT_W-1:0] ticks(input logic [PRESCALE_W-1:0] p,
                                               input int unsigned         sh);
        return (CNT_W'(p) << sh) - CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// AXI4-Stream style word channel carrying received UART words.
interface uart_rx_framer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_sync_bit.sv
// Two-flop synchroniser for a single asynchronous input bit.
module uart_sync_bit #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: start detection, mid-bit sampling, stop check, and a
// one-word AXI4-Stream output register with framing/overrun pulses.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_framer_if.master      m_axis,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [PRESCALE_W-1:0] prescale
);

    logic                  w_rxs;
    rx_state_e             r_state;
    logic [PRESCALE_W-1:0] r_p;
    logic [CNT_W-1:0]      r_cnt;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_busy;
    logic                  r_overrun;
    logic                  r_frame_err;

    uart_sync_bit #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rxd),
        .o_q   (w_rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_p         <= '0;
            r_cnt       <= '0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_tvalid && m_axis.tready) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    // A zero prescale disables reception entirely.
                    if (!w_rxs && (prescale != '0)) begin
                        r_p     <= prescale;
                        r_cnt   <= ticks(prescale, HALF_SHIFT);
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!w_rxs) begin
                        r_cnt   <= ticks(r_p, PRESCALE_SHIFT);
                        r_bcnt  <= BCNT_W'(DATA_WIDTH);
                        r_state <= ST_DATA;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_shift <= {w_rxs, r_shift[DATA_WIDTH-1:1]};
                        r_bcnt  <= r_bcnt - BCNT_W'(1);
                        r_cnt   <= ticks(r_p, PRESCALE_SHIFT);
                        if (r_bcnt == BCNT_W'(1)) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (w_rxs) begin
                        // Overwrite an unaccepted word; flag only if it is not taken this cycle.
                        r_tdata   <= r_shift;
                        r_tvalid  <= 1'b1;
                        r_overrun <= r_tvalid && !m_axis.tready;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis.tdata   = r_tdata;
    assign m_axis.tvalid  = r_tvalid;
    assign busy           = r_busy;
    assign overrun_error  = r_overrun;
    assign frame_error    = r_frame_err;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: directed scenarios plus random
// frames compared against a queue-based word/error model.
module tb_uart_rx_framer;

    localparam int unsigned DW = 8;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        rxd      = 1'b1;
    logic [15:0] prescale = 16'd1;
    logic        busy;
    logic        ovr;
    logic        ferr;

    uart_rx_framer_if #(.DATA_WIDTH(DW)) axis_if ();

    uart_rx_framer #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_axis        (axis_if),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (ovr),
        .frame_error   (ferr),
        .prescale      (prescale)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc       = 0;
    int n_ferr    = 0;
    int n_ovr     = 0;
    int busy_cyc  = 0;
    int rise_cyc  = 0;
    logic prev_tvalid = 1'b0;
    logic [DW-1:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: accepted words, error pulses, busy time.
    always @(negedge clk) begin
        if (axis_if.tvalid === 1'b1 && axis_if.tready === 1'b1) got_q.push_back(axis_if.tdata);
        if (ferr === 1'b1) n_ferr <= n_ferr + 1;
        if (ovr === 1'b1)  n_ovr  <= n_ovr + 1;
        if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
        if (axis_if.tvalid === 1'b1 && prev_tvalid !== 1'b1) rise_cyc <= cyc;
        prev_tvalid <= axis_if.tvalid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        if (i < got_q.size()) return 32'(got_q[i]);
        return 'x;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int p);
        rxd = b;
        cycles(p * 8);
    endtask

    // Line is left at the stop value so a low stop can be extended into a break.
    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic stop);
        send_bit(1'b0, p);
        for (int i = 0; i < DW; i++) send_bit(d[i], p);
        send_bit(stop, p);
    endtask

    int base, f0, o0, b0, t0, lat;
    logic [DW-1:0] exp_q[$];
    int exp_ferr;

    initial begin
        axis_if.tready = 1'b1;
        rst_n = 1'b0;
        cycles(3);
        chk("rst_tvalid", 32'(axis_if.tvalid), 32'd0);
        chk("rst_tdata",  32'(axis_if.tdata),  32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_ovr",    32'(ovr),  32'd0);
        chk("rst_ferr",   32'(ferr), 32'd0);
        rst_n = 1'b1;
        cycles(3);

        // Single frame, latency measured from the first sampling edge of the start bit.
        prescale = 16'd1;
        base = got_q.size(); f0 = n_ferr; o0 = n_ovr;
        t0 = cyc + 1;
        send_frame(8'hA5, 1, 1'b1);
        cycles(4);
        lat = rise_cyc - t0;
        chk("a5_count", 32'(got_q.size() - base), 32'd1);
        chk("a5_data",  word_at(base), 32'hA5);
        chk("a5_latency_77_79", 32'(lat >= 77 && lat <= 79), 32'd1);
        chk("a5_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("a5_no_ovr",  32'(n_ovr - o0),  32'd0);

        // Back-to-back words with no consumer: the second overruns the first.
        axis_if.tready = 1'b0;
        prescale = 16'd2;
        o0 = n_ovr;
        send_frame(8'h3C, 2, 1'b1);
        chk("ovr_first_valid", 32'(axis_if.tvalid), 32'd1);
        chk("ovr_first_data",  32'(axis_if.tdata),  32'h3C);
        send_frame(8'hC3, 2, 1'b1);
        cycles(2);
        chk("ovr_second_data",  32'(axis_if.tdata),  32'hC3);
        chk("ovr_second_valid", 32'(axis_if.tvalid), 32'd1);
        chk("ovr_pulse_once",   32'(n_ovr - o0), 32'd1);
        base = got_q.size();
        axis_if.tready = 1'b1;
        cycles(3);
        chk("ovr_drain_count", 32'(got_q.size() - base), 32'd1);
        chk("ovr_drain_data",  word_at(base), 32'hC3);
        chk("ovr_drain_valid", 32'(axis_if.tvalid), 32'd0);

        // Low stop bit followed by a held-low line.
        prescale = 16'd1;
        base = got_q.size(); f0 = n_ferr;
        send_frame(8'h55, 1, 1'b0);
        cycles(40);
        chk("brk_one_ferr",  32'(n_ferr - f0), 32'd1);
        chk("brk_no_word",   32'(got_q.size() - base), 32'd0);
        chk("brk_tvalid",    32'(axis_if.tvalid), 32'd0);
        chk("brk_busy_held", 32'(busy), 32'd1);
        rxd = 1'b1;
        cycles(5);
        chk("brk_busy_clear", 32'(busy), 32'd0);
        chk("brk_still_one_ferr", 32'(n_ferr - f0), 32'd1);
        base = got_q.size();
        send_frame(8'h12, 1, 1'b1);
        cycles(4);
        chk("after_brk_data", word_at(base), 32'h12);

        // Short glitch on an idle line is rejected at the start-bit midpoint.
        b0 = busy_cyc; base = got_q.size(); f0 = n_ferr;
        rxd = 1'b0;
        cycles(2);
        rxd = 1'b1;
        cycles(20);
        chk("glitch_busy_1_6", 32'((busy_cyc - b0) >= 1 && (busy_cyc - b0) <= 6), 32'd1);
        chk("glitch_no_word",  32'(got_q.size() - base), 32'd0);
        chk("glitch_no_ferr",  32'(n_ferr - f0), 32'd0);
        chk("glitch_idle",     32'(busy), 32'd0);

        // Asynchronous reset in the middle of a 0xFF frame.
        f0 = n_ferr; o0 = n_ovr;
        rxd = 1'b0;
        cycles(8);
        rxd = 1'b1;
        cycles(30);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_busy",   32'(busy), 32'd0);
        chk("arst_tvalid", 32'(axis_if.tvalid), 32'd0);
        chk("arst_tdata",  32'(axis_if.tdata), 32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(5);
        chk("arst_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("arst_no_ovr",  32'(n_ovr - o0), 32'd0);
        base = got_q.size();
        send_frame(8'h81, 1, 1'b1);
        cycles(4);
        chk("arst_next_data", word_at(base), 32'h81);

        // prescale of zero disables the receiver.
        prescale = 16'd0;
        b0 = busy_cyc; base = got_q.size();
        for (int i = 0; i < 50; i++) begin
            rxd = 1'($urandom);
            cycles(1);
        end
        rxd = 1'b1;
        cycles(5);
        chk("p0_never_busy", 32'(busy_cyc - b0), 32'd0);
        chk("p0_no_word",    32'(got_q.size() - base), 32'd0);
        prescale = 16'd3;
        base = got_q.size();
        send_frame(8'h7E, 3, 1'b1);
        cycles(4);
        chk("p3_data", word_at(base), 32'h7E);

        // Random frames: varying prescale, data, stop validity and idle gaps.
        base = got_q.size(); f0 = n_ferr; exp_ferr = 0;
        for (int k = 0; k < 24; k++) begin
            int p;
            logic [DW-1:0] d;
            logic good;
            p    = int'($urandom_range(1, 4));
            d    = DW'($urandom);
            good = ($urandom_range(0, 5) != 0);
            prescale = 16'(p);
            send_frame(d, p, good);
            if (good) begin
                exp_q.push_back(d);
                cycles(int'($urandom_range(0, 8)));
            end else begin
                exp_ferr++;
                rxd = 1'b1;
                cycles(int'($urandom_range(2, 8)));
            end
        end
        cycles(10);
        chk("rand_word_count", 32'(got_q.size() - base), 32'(exp_q.size()));
        chk("rand_ferr_count", 32'(n_ferr - f0), 32'(exp_ferr));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("rand_word_%0d", i), word_at(base + i), 32'(exp_q[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
